avalon_mem_responder: RTL and testbench

Avalon-MM slave that serves the CPU's instruction and data bus requests from an on-chip word RAM. It is the responder end of the bus driven by the fetch and memory stages. It accepts one read or write at a time, holds the master with `waitrequest` for a fixed, parameterised number of cycles, and returns read data with the completing cycle. It is used as the simulation/FPGA memory behind the pipelined MIPS core.

---
 rtl/avalon_pkg.sv | 15 +
 rtl/word_ram.sv | 33 +++
 rtl/avalon_mem_responder.sv | 119 +++++++++++
 tb/tb_avalon_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } resp_state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/word_ram.sv
// Single-port word RAM: synchronous read that holds its output, per-byte write enables.
module word_ram
    import avalon_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [BE_W-1:0]   byteenable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(1 << ADDR_W)-1];

    // rdata only moves on an enabled read, so the last read result is held
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[addr];
        end
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byteenable[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave serving one read or write at a time from an on-chip word RAM,
// stretching every transfer with waitrequest for LATENCY cycles.
module avalon_mem_responder
    import avalon_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = RESET_VECTOR,
    parameter int          LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       address,
    input  logic [BE_W-1:0]   byteenable,
    input  logic [WORD_W-1:0] writedata,
    output logic              waitrequest,
    output logic [WORD_W-1:0] readdata
);

    generate
        if (LATENCY < 2) begin : g_bad_latency
            $error("avalon_mem_responder: LATENCY must be at least 2");
        end
    endgenerate

    localparam int                CNT_W    = $clog2(LATENCY);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 2);

    resp_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              req;
    logic              last_busy;
    logic              in_range;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] idx;
    logic              ram_rd, ram_wr;
    logic              rd_zero;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_low_bits;

    assign req             = read | write;
    assign offset          = address - BASE_ADDR;
    assign in_range        = (offset >> (ADDR_W + 2)) == 32'd0;
    assign idx             = offset[ADDR_W+1:2];
    assign unused_low_bits = ^offset[1:0];

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        waitrequest = 1'b0;
        last_busy   = 1'b0;
        case (state)
            IDLE: begin
                waitrequest = req;
                if (req) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                waitrequest = 1'b1;
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    last_busy  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            waitrequest = req;
        end
    end

    // A simultaneous read+write is a write; reset kills any access in flight
    assign ram_wr = last_busy & write & in_range & ~reset;
    assign ram_rd = last_busy & read & ~write & in_range & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_zero <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (last_busy && read && !write) begin
                rd_zero <= ~in_range;
            end
        end
    end

    // The RAM holds its last read word; rd_zero forces zero after reset or an out-of-range read
    assign readdata = rd_zero ? '0 : ram_rdata;

    word_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk        (clk),
        .rd_en      (ram_rd),
        .wr_en      (ram_wr),
        .byteenable (byteenable),
        .addr       (idx),
        .wdata      (writedata),
        .rdata      (ram_rdata)
    );

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder: driver pushes expected results, monitor checks completions.
module tb_avalon_mem_responder;

    localparam int          ADDR_W = 10;
    localparam int          LAT    = 2;
    localparam int          WORDS  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    always #5 clk = ~clk;

    avalon_mem_responder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .read        (read),
        .write       (write),
        .address     (address),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    logic [31:0] model_mem [0:WORDS-1];
    logic [31:0] last_rd;
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          wait_cycles = 0;

    function automatic bit model_in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(WORDS * 4);
    endfunction

    // Behavioural memory: a read+write pair counts as a write and leaves readdata alone
    function automatic void model_access(input logic rd, input logic wr, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] be);
        logic [31:0] off;
        off = a - BASE;
        if (wr) begin
            if (model_in_range(a)) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model_mem[off >> 2][8*i +: 8] = d[8*i +: 8];
                end
            end
        end else if (rd) begin
            last_rd = model_in_range(a) ? model_mem[off >> 2] : 32'h0;
        end
        exp_q.push_back(last_rd);
    endfunction

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Monitor: every cycle that completes a transfer is matched against the scoreboard
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (reset || !(read || write)) begin
                wait_cycles = 0;
            end else if (waitrequest) begin
                wait_cycles++;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_completion: got a completion, expected none at %0t", $time);
                end else begin
                    exp = exp_q.pop_front();
                    checkOutput("readdata", readdata, exp);
                    checkOutput("latency", 32'(wait_cycles), 32'(LAT));
                end
                wait_cycles = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completing cycle
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] be, input bit keep);
        bit done;
        done       = 1'b0;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = d;
        byteenable = be;
        model_access(rd, wr, a, d, be);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!waitrequest) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: got no completion in 20 cycles, expected %0d at addr %h", LAT, a);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            read  = 1'b0;
            write = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0: a = BASE - 32'd4;
            1: a = BASE + 32'(WORDS * 4);
            2: begin
                a = $urandom();
                if (model_in_range(a)) a = 32'h0;
            end
            3: a = BASE + 32'(4 * (WORDS - 4 + $urandom_range(0, 3))) + 32'($urandom_range(0, 3));
            default: a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
        endcase
        return a;
    endfunction

    initial begin
        int op;
        reset      = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = BASE;
        writedata  = 32'h0;
        byteenable = 4'h0;
        last_rd    = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_waitrequest", 32'(waitrequest), 32'd1);
        checkOutput("reset_readdata", readdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        read  = 1'b0;
        @(negedge clk);
        checkOutput("idle_waitrequest", 32'(waitrequest), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] directed transfers");
        applyStimulus(1'b0, 1'b1, BASE,         32'h3C081234, 4'hF, 1'b0);
        applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'hFFFFFFFF, 4'hF, 1'b0);
        applyStimulus(1'b1, 1'b0, BASE,         32'h0,        4'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'h00AB00CD, 4'b0101, 1'b0);
        applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'h0,        4'hF, 1'b0);

        for (int w = 2; w < 64; w++)
            applyStimulus(1'b0, 1'b1, BASE + 32'(4 * w), $urandom(), 4'hF, 1'b0);
        for (int w = WORDS - 4; w < WORDS; w++)
            applyStimulus(1'b0, 1'b1, BASE + 32'(4 * w), $urandom(), 4'hF, 1'b0);

        applyStimulus(1'b1, 1'b0, BASE,         32'h0, 4'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'h0, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h00000000,           32'h0,        4'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h00000000,           32'hDEADBEEF, 4'hF, 1'b0);
        applyStimulus(1'b0, 1'b1, BASE + 32'(WORDS * 4),  32'hCAFEF00D, 4'hF, 1'b0);
        applyStimulus(1'b0, 1'b1, BASE - 32'd4,           32'h0BADF00D, 4'hF, 1'b0);
        applyStimulus(1'b1, 1'b0, BASE,                   32'h0,        4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, BASE + 32'(4 * (WORDS - 1)), 32'h0,   4'h0, 1'b0);

        applyStimulus(1'b0, 1'b1, BASE + 32'd8, 32'h12345678, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, BASE + 32'd8, 32'h0,        4'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, BASE + 32'd8, 32'hA5A5A5A5, 4'b0011, 1'b0);
        applyStimulus(1'b1, 1'b0, BASE + 32'd8, 32'h0,        4'h0, 1'b0);

        $display("[TB] abort cases");
        read    = 1'b1;
        address = BASE + 32'd16;
        @(negedge clk);
        @(negedge clk);
        #1;
        read = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abort_read_waitrequest", 32'(waitrequest), 32'd0);
        checkOutput("abort_read_readdata", readdata, last_rd);
        @(posedge clk);
        #1;

        write      = 1'b1;
        address    = BASE + 32'd12;
        writedata  = 32'h87654321;
        byteenable = 4'hF;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abort_reset_waitrequest", 32'(waitrequest), 32'd1);
        checkOutput("abort_reset_readdata", readdata, 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        write   = 1'b0;
        last_rd = 32'h0;
        applyStimulus(1'b1, 1'b0, BASE + 32'd12, 32'h0, 4'h0, 1'b0);

        $display("[TB] random transfers");
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 9);
            applyStimulus(op < 5 || op == 9, op >= 5, pick_addr(), $urandom(),
                          4'($urandom_range(0, 15)), (k < 149) && ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
